mem_port_arbiter: RTL and testbench

Sequential arbiter that shares the single-port 1K x 16 `Memory` block between the instruction-fetch stage and the data (load/store) stage of the 16-bit processor. It accepts request/acknowledge handshakes from both ports, serialises them onto the memory's address, data and write-enable pins, and captures read data. Data accesses have priority, with a starvation guard so fetch always makes progress. It sits between the pipeline front end and `Memory`; the register file and ALU never drive the memory directly.

---
 rtl/mem_port_arbiter_if.sv | 37 +++
 rtl/mem_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Handshake and memory-pin bundle between the pipeline's fetch/data ports,
// the arbiter, and the single-port Memory block.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
);
  logic              I_Req;
  logic [ADDR_W-1:0] I_Addr;
  logic              I_Ack;
  logic [DATA_W-1:0] I_RData;

  logic              D_Req;
  logic              D_WE;
  logic [ADDR_W-1:0] D_Addr;
  logic [DATA_W-1:0] D_WData;
  logic              D_Ack;
  logic [DATA_W-1:0] D_RData;

  logic [ADDR_W-1:0] Mem_Addr;
  logic [DATA_W-1:0] Mem_DataIn;
  logic              Mem_WE;
  logic [DATA_W-1:0] Mem_DataOut;

  logic              Busy;

  // Arbiter side.
  modport slave (
    input  I_Req, I_Addr, D_Req, D_WE, D_Addr, D_WData, Mem_DataOut,
    output I_Ack, I_RData, D_Ack, D_RData, Mem_Addr, Mem_DataIn, Mem_WE, Busy
  );

  // Requester / memory side.
  modport master (
    output I_Req, I_Addr, D_Req, D_WE, D_Addr, D_WData, Mem_DataOut,
    input  I_Ack, I_RData, D_Ack, D_RData, Mem_Addr, Mem_DataIn, Mem_WE, Busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and load/store requests onto the single-port Memory block.
// Data has priority; a starvation counter forces a fetch after STARVE_LIMIT data grants.
module mem_port_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 2
) (
  input logic               CLK,
  input logic               Reset,
  mem_port_arbiter_if.slave bus
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, ACK} state_t;
  typedef enum logic {PORT_I, PORT_D} port_t;

  state_t            state, stateNext;
  port_t             owner, ownerNext;
  logic              isStore, isStoreNext;
  logic [CNT_W-1:0]  starveCnt, starveCntNext;
  logic [ADDR_W-1:0] memAddr, memAddrNext;
  logic [DATA_W-1:0] memDataIn, memDataInNext;
  logic              memWe, memWeNext;
  logic              iAck, iAckNext;
  logic              dAck, dAckNext;
  logic [DATA_W-1:0] iRData, iRDataNext;
  logic [DATA_W-1:0] dRData, dRDataNext;
  logic              busy;

  logic forceFetch;
  logic grantI;
  logic grantD;

  // Grant decision: full arbitration from IDLE, hand-off to the other port from ACK.
  always_comb begin
    forceFetch = bus.I_Req && (starveCnt == CNT_MAX);
    grantI     = 1'b0;
    grantD     = 1'b0;
    case (state)
      IDLE: begin
        grantD = bus.D_Req && !forceFetch;
        grantI = bus.I_Req && !grantD;
      end
      ACK: begin
        grantI = (owner == PORT_D) && bus.I_Req;
        grantD = (owner == PORT_I) && bus.D_Req;
      end
      default: ;
    endcase
  end

  always_comb begin
    // NOTE: every signal gets a default before the case; a branch that skips one would infer a latch.
    stateNext     = state;
    ownerNext     = owner;
    isStoreNext   = isStore;
    starveCntNext = starveCnt;
    memAddrNext   = memAddr;
    memDataInNext = memDataIn;
    memWeNext     = 1'b0;
    iAckNext      = 1'b0;
    dAckNext      = 1'b0;
    iRDataNext    = iRData;
    dRDataNext    = dRData;

    unique case (state)
      IDLE:    stateNext = IDLE;
      ACCESS:  stateNext = CAPTURE;
      CAPTURE: begin
        stateNext = ACK;
        if (owner == PORT_I) begin
          iAckNext   = 1'b1;
          iRDataNext = bus.Mem_DataOut;
        end else begin
          dAckNext = 1'b1;
          if (!isStore) dRDataNext = bus.Mem_DataOut;
        end
      end
      ACK:     stateNext = IDLE;
    endcase

    if (grantI) begin
      stateNext     = ACCESS;
      ownerNext     = PORT_I;
      isStoreNext   = 1'b0;
      memAddrNext   = bus.I_Addr;
      starveCntNext = '0;
    end else if (grantD) begin
      stateNext     = ACCESS;
      ownerNext     = PORT_D;
      isStoreNext   = bus.D_WE;
      memAddrNext   = bus.D_Addr;
      memDataInNext = bus.D_WData;
      memWeNext     = bus.D_WE;
      // Only data grants that overtake a waiting fetch count towards starvation.
      if (!bus.I_Req)                starveCntNext = '0;
      else if (starveCnt != CNT_MAX) starveCntNext = starveCnt + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      owner     <= PORT_I;
      isStore   <= 1'b0;
      starveCnt <= '0;
      memAddr   <= '0;
      memDataIn <= '0;
      memWe     <= 1'b0;
      iAck      <= 1'b0;
      dAck      <= 1'b0;
      iRData    <= '0;
      dRData    <= '0;
      busy      <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register sees pre-edge values regardless of statement order.
      state     <= stateNext;
      owner     <= ownerNext;
      isStore   <= isStoreNext;
      starveCnt <= starveCntNext;
      memAddr   <= memAddrNext;
      memDataIn <= memDataInNext;
      memWe     <= memWeNext;
      iAck      <= iAckNext;
      dAck      <= dAckNext;
      iRData    <= iRDataNext;
      dRData    <= dRDataNext;
      busy      <= (stateNext != IDLE);
    end
  end

  assign bus.Mem_Addr   = memAddr;
  assign bus.Mem_DataIn = memDataIn;
  assign bus.Mem_WE     = memWe;
  assign bus.I_Ack      = iAck;
  assign bus.D_Ack      = dAck;
  assign bus.I_RData    = iRData;
  assign bus.D_RData    = dRData;
  assign bus.Busy       = busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a timeline model (grant edge + age) predicts every
// output each cycle; directed scenarios pin latency, ordering and read data.
module tb_mem_port_arbiter;

  localparam int STARVE_LIMIT = 2;

  logic CLK;
  logic Reset;

  mem_port_arbiter_if #(.ADDR_W(10), .DATA_W(16)) bus ();

  mem_port_arbiter #(
    .ADDR_W(10), .DATA_W(16), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .CLK  (CLK),
    .Reset(Reset),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Synchronous single-port memory standing in for the Memory block.
  logic [15:0] mem [1024] = '{default: '0};
  always @(posedge CLK) begin
    if (bus.Mem_WE) mem[bus.Mem_Addr] <= bus.Mem_DataIn;
    bus.Mem_DataOut <= mem[bus.Mem_Addr];
  end

  int nChecks = 0;
  int nPassed = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual === expected) nPassed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
  endtask

  // ---------------- reference model ----------------
  // A transaction is described by its grant edge; everything else follows from its age.
  int          t = 0;
  bit          haveTxn = 0;
  int          gEdge;
  bit          gIsI;
  bit          gWe;
  logic [9:0]  gAddr;
  logic [15:0] gData;
  int          cnt = 0;
  logic [15:0] refMem [1024] = '{default: '0};

  logic        eIAck = 0, eDAck = 0, eMemWe = 0, eBusy = 0;
  logic [9:0]  eMemAddr = '0;
  logic [15:0] eMemDataIn = '0, eIRData = '0, eDRData = '0;

  always @(posedge CLK) begin
    int age;
    bit gI, gD, forceI;
    t++;
    if (Reset) begin
      haveTxn = 0; cnt = 0;
      eIAck = 0; eDAck = 0; eMemWe = 0; eBusy = 0;
      eMemAddr = '0; eMemDataIn = '0; eIRData = '0; eDRData = '0;
    end else begin
      age = haveTxn ? t - gEdge : 99;
      if (age == 1 && gWe) refMem[gAddr] = gData;
      eIAck = (age == 2) && gIsI;
      eDAck = (age == 2) && !gIsI;
      if (age == 2 && !gWe) begin
        if (gIsI) eIRData = refMem[gAddr];
        else      eDRData = refMem[gAddr];
      end
      gI = 0; gD = 0;
      if (age == 3) begin
        gI = !gIsI && bus.I_Req;
        gD = gIsI && bus.D_Req;
      end else if (age >= 4) begin
        forceI = bus.I_Req && (cnt == STARVE_LIMIT);
        gD = bus.D_Req && !forceI;
        gI = bus.I_Req && !gD;
      end
      eMemWe = 0;
      if (gI || gD) begin
        if (gI)             cnt = 0;
        else if (bus.I_Req) cnt = (cnt < STARVE_LIMIT) ? cnt + 1 : cnt;
        else                cnt = 0;
        haveTxn = 1;
        gEdge   = t;
        gIsI    = gI;
        gWe     = gD && bus.D_WE;
        gAddr   = gI ? bus.I_Addr : bus.D_Addr;
        gData   = bus.D_WData;
        eMemAddr = gAddr;
        eMemWe   = gWe;
        if (gD) eMemDataIn = bus.D_WData;
      end
      eBusy = haveTxn && (t - gEdge) <= 2;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(posedge CLK);
    #2;
    check("i_ack",       32'(bus.I_Ack),      32'(eIAck));
    check("d_ack",       32'(bus.D_Ack),      32'(eDAck));
    check("i_rdata",     32'(bus.I_RData),    32'(eIRData));
    check("d_rdata",     32'(bus.D_RData),    32'(eDRData));
    check("mem_we",      32'(bus.Mem_WE),     32'(eMemWe));
    check("mem_addr",    32'(bus.Mem_Addr),   32'(eMemAddr));
    check("mem_data_in", 32'(bus.Mem_DataIn), 32'(eMemDataIn));
    check("busy",        32'(bus.Busy),       32'(eBusy));
  end

  // ---------------- directed stimulus ----------------
  task automatic dAccess(input logic we, input logic [9:0] addr, input logic [15:0] wdata,
                         output int lat, output int weCycles, output logic [15:0] rdata);
    int t0;
    bit seen;
    @(negedge CLK);
    bus.D_Req = 1'b1; bus.D_WE = we; bus.D_Addr = addr; bus.D_WData = wdata;
    t0 = t; weCycles = 0; seen = 0; lat = -1; rdata = 'x;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge CLK);
      if (bus.Mem_WE) weCycles++;
      if (bus.D_Ack) begin
        seen = 1; lat = t - t0; rdata = bus.D_RData; bus.D_Req = 1'b0;
      end
    end
    bus.D_Req = 1'b0;
    check("d_ack_seen", 32'(seen), 32'd1);
  endtask

  task automatic iAccess(input logic [9:0] addr, output int lat,
                         output logic [15:0] rdata, output logic [15:0] dSnap);
    int t0;
    bit seen;
    @(negedge CLK);
    bus.I_Req = 1'b1; bus.I_Addr = addr;
    t0 = t; seen = 0; lat = -1; rdata = 'x; dSnap = 'x;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge CLK);
      if (bus.I_Ack) begin
        seen = 1; lat = t - t0; rdata = bus.I_RData; dSnap = bus.D_RData; bus.I_Req = 1'b0;
      end
    end
    bus.I_Req = 1'b0;
    check("i_ack_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    int lat, weCycles, dT, iT, nAcks;
    logic [15:0] rdata, dSnap;
    bit seen, restoreI, ackSeen;
    int ackOrder [6];
    bit expOrder [6] = '{1, 1, 0, 1, 1, 0};

    // Reset held two cycles with a store request pending.
    Reset = 1'b1;
    bus.I_Req = 1'b0; bus.I_Addr = '0;
    bus.D_Req = 1'b1; bus.D_WE = 1'b1; bus.D_Addr = 10'd2; bus.D_WData = 16'h0055;
    repeat (2) @(negedge CLK);
    check("rst_busy",   32'(bus.Busy),   32'd0);
    check("rst_mem_we", 32'(bus.Mem_WE), 32'd0);
    check("rst_acks",   32'({bus.I_Ack, bus.D_Ack}), 32'd0);
    check("rst_rdata",  32'({bus.I_RData, bus.D_RData}), 32'd0);
    Reset = 1'b0;
    @(negedge CLK);
    check("grant_after_reset", 32'({bus.Busy, bus.Mem_WE, bus.Mem_Addr}), 32'({1'b1, 1'b1, 10'd2}));
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      if (bus.D_Ack) begin seen = 1; bus.D_Req = 1'b0; end
      else @(negedge CLK);
    end
    bus.D_Req = 1'b0;
    check("rst_store_ack", 32'(seen), 32'd1);

    // Store 15 to address 1, then load it back.
    dAccess(1'b1, 10'd1, 16'd15, lat, weCycles, rdata);
    check("store_latency", 32'(lat), 32'd3);
    check("store_we_cycles", 32'(weCycles), 32'd1);
    dAccess(1'b0, 10'd1, 16'h0000, lat, weCycles, rdata);
    check("load_latency", 32'(lat), 32'd3);
    check("load_we_cycles", 32'(weCycles), 32'd0);
    check("load_rdata", 32'(rdata), 32'h000F);

    // Fetch after preloading, including the top address.
    dAccess(1'b1, 10'd15, 16'h0001, lat, weCycles, rdata);
    dAccess(1'b1, 10'h3FF, 16'hBEEF, lat, weCycles, rdata);
    iAccess(10'd15, lat, rdata, dSnap);
    check("fetch_latency", 32'(lat), 32'd3);
    check("fetch_rdata", 32'(rdata), 32'h0001);
    check("fetch_d_rdata_kept", 32'(dSnap), 32'h000F);
    iAccess(10'h3FF, lat, rdata, dSnap);
    check("fetch_top_addr", 32'(rdata), 32'hBEEF);

    // Simultaneous requests: data first, fetch handed over from ACK.
    @(negedge CLK);
    bus.D_Req = 1'b1; bus.D_WE = 1'b0; bus.D_Addr = 10'd2;
    bus.I_Req = 1'b1; bus.I_Addr = 10'd1;
    dT = -1; iT = -1;
    for (int k = 0; k < 20 && iT < 0; k++) begin
      @(negedge CLK);
      if (bus.D_Ack) begin dT = t; bus.D_Req = 1'b0; check("simul_d_rdata", 32'(bus.D_RData), 32'h0055); end
      if (bus.I_Ack) begin iT = t; bus.I_Req = 1'b0; check("simul_i_rdata", 32'(bus.I_RData), 32'h000F); end
    end
    bus.D_Req = 1'b0; bus.I_Req = 1'b0;
    check("simul_d_first", 32'(dT >= 0 && dT < iT), 32'd1);
    check("simul_i_gap", 32'(iT - dT), 32'd3);

    // Starvation: data keeps requesting fresh stores; fetch stays pending but
    // stalls for one cycle after each data ack, so data wins from IDLE until forced.
    @(negedge CLK);
    bus.D_Req = 1'b1; bus.D_WE = 1'b1; bus.D_Addr = 10'd100; bus.D_WData = 16'hA000;
    bus.I_Req = 1'b1; bus.I_Addr = 10'd1;
    nAcks = 0; restoreI = 0;
    for (int k = 0; k < 80 && nAcks < 6; k++) begin
      @(negedge CLK);
      if (restoreI) begin bus.I_Req = 1'b1; restoreI = 0; end
      if (bus.D_Ack) begin
        ackOrder[nAcks] = 1; nAcks++;
        bus.D_Addr = bus.D_Addr + 10'd1; bus.D_WData = bus.D_WData + 16'd1;
        bus.I_Req = 1'b0; restoreI = 1;
      end else if (bus.I_Ack) begin
        ackOrder[nAcks] = 0; nAcks++;
        bus.I_Addr = (bus.I_Addr == 10'd1) ? 10'd15 : 10'd1;
      end
    end
    bus.D_Req = 1'b0; bus.I_Req = 1'b0;
    check("starve_ack_count", 32'(nAcks), 32'd6);
    for (int k = 0; k < 6; k++) check($sformatf("starve_order_%0d", k), 32'(ackOrder[k]), 32'(expOrder[k]));

    // Reset during ACCESS of a store of 127 to address 1 aborts it.
    repeat (2) @(negedge CLK);
    bus.D_Req = 1'b1; bus.D_WE = 1'b1; bus.D_Addr = 10'd1; bus.D_WData = 16'd127;
    @(negedge CLK);
    check("abort_in_access", 32'({bus.Busy, bus.Mem_WE}), 32'd3);
    Reset = 1'b1; bus.D_Req = 1'b0;
    #1;
    check("abort_we_async", 32'(bus.Mem_WE), 32'd0);
    ackSeen = 0;
    repeat (2) begin @(negedge CLK); if (bus.D_Ack) ackSeen = 1; end
    Reset = 1'b0;
    repeat (6) begin @(negedge CLK); if (bus.D_Ack) ackSeen = 1; end
    check("abort_no_ack", 32'(ackSeen), 32'd0);
    dAccess(1'b0, 10'd1, 16'h0000, lat, weCycles, rdata);
    check("abort_mem_kept", 32'(rdata), 32'd15);

    repeat (3) @(negedge CLK);
    $display("%0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got %0d/%0d", nPassed, nChecks);
    $fatal(1);
  end

endmodule
